// File: rtl/nand_pc_stack.sv
`default_nettype none
// ============================================================================
// Module   : nand_pc_stack
// Purpose  : Program counter with a LIFO return-address stack
//            (call / ret / load / inc / clr) and a sticky over/underflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module nand_pc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       ret,
    input  logic                       call,
    input  logic                       load,
    input  logic                       inc,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [WIDTH-1:0] r_pc;
    logic [CW-1:0]    r_count;
    logic             r_err;

    logic [WIDTH-1:0] w_pc_inc;
    logic [CW-1:0]    w_cnt_m1;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_push;

    assign w_pc_inc  = r_pc + WIDTH'(1);
    assign w_cnt_m1  = r_count - CW'(1);
    assign w_wr_idx  = r_count[AW-1:0];
    assign w_top_idx = w_cnt_m1[AW-1:0];
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);

    // Only a call that actually wins arbitration and fits may touch storage.
    assign w_push = call && !clr && !ret && !w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (clr) begin
            r_pc    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (ret) begin
            if (w_empty) begin
                r_err <= 1'b1;
            end else begin
                r_pc    <= r_stack[w_top_idx];
                r_count <= w_cnt_m1;
            end
        end else if (call) begin
            if (w_full) begin
                r_err <= 1'b1;
            end else begin
                r_pc    <= in;
                r_count <= r_count + CW'(1);
            end
        end else if (load) begin
            r_pc <= in;
        end else if (inc) begin
            r_pc <= w_pc_inc;
        end
    end

    assign out   = r_pc;
    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nand_pc_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_nand_pc_stack
// Purpose  : Scoreboard bench for nand_pc_stack against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nand_pc_stack;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    typedef struct packed {
        logic [W-1:0]  pc;
        logic [CW-1:0] cnt;
        logic          full;
        logic          empty;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr, ret, call, load, inc;
    logic [W-1:0]  din;
    logic [W-1:0]  out;
    logic [CW-1:0] count;
    logic          full, empty, err;

    int n_vec = 0;
    int n_bad = 0;

    exp_t         sb [$];
    logic [W-1:0] m_stk [$];
    logic [W-1:0] m_pc;
    logic         m_err;

    always #5 clk = ~clk;

    nand_pc_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .ret   (ret),
        .call  (call),
        .load  (load),
        .inc   (inc),
        .in    (din),
        .out   (out),
        .count (count),
        .full  (full),
        .empty (empty),
        .err   (err)
    );

    function automatic exp_t model_view();
        exp_t e;
        e.pc    = m_pc;
        e.cnt   = CW'(m_stk.size());
        e.full  = (m_stk.size() == D);
        e.empty = (m_stk.size() == 0);
        e.err   = m_err;
        return e;
    endfunction

    task automatic model_reset();
        m_pc  = '0;
        m_err = 1'b0;
        m_stk.delete();
    endtask

    task automatic compare(input string name, input exp_t act, input exp_t e);
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got out=%h count=%0d full=%b empty=%b err=%b, expected out=%h count=%0d full=%b empty=%b err=%b",
                     name, act.pc, act.cnt, act.full, act.empty, act.err,
                     e.pc, e.cnt, e.full, e.empty, e.err);
        end
    endtask

    function automatic exp_t dut_view();
        exp_t a;
        a.pc    = out;
        a.cnt   = count;
        a.full  = full;
        a.empty = empty;
        a.err   = err;
        return a;
    endfunction

    // Monitor: the DUT presents a new state after every rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            compare($sformatf("vec%0d", n_vec), dut_view(), sb.pop_front());
        end
    end

    task automatic step(input logic c, input logic r, input logic ca,
                        input logic l, input logic i, input logic [W-1:0] a);
        clr = c; ret = r; call = ca; load = l; inc = i; din = a;
        if (c) begin
            model_reset();
        end else if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_err = 1'b1;
        end else if (ca) begin
            if (m_stk.size() < D) begin
                m_stk.push_back(m_pc + W'(1));
                m_pc = a;
            end else begin
                m_err = 1'b1;
            end
        end else if (l) begin
            m_pc = a;
        end else if (i) begin
            m_pc = m_pc + W'(1);
        end
        sb.push_back(model_view());
        @(posedge clk);
        #2;
        clr = 0; ret = 0; call = 0; load = 0; inc = 0;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare(name, dut_view(), model_view());
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t spot;
        rst_n = 1'b0;
        clr = 0; ret = 0; call = 0; load = 0; inc = 0; din = '0;
        model_reset();
        #3;
        compare("por", dut_view(), model_view());
        #14;
        rst_n = 1'b1;

        // inc x3 then load
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);
        spot = '{pc: 16'h0003, cnt: '0, full: 1'b0, empty: 1'b1, err: 1'b0};
        compare("inc3", dut_view(), spot);
        step(0, 0, 0, 1, 0, 16'h0100);

        // nested call / ret
        step(0, 0, 0, 1, 0, 16'h0010);
        step(0, 0, 1, 0, 0, 16'h0200);
        step(0, 0, 1, 0, 0, 16'h0300);
        step(0, 1, 0, 0, 0, '0);
        step(0, 1, 0, 0, 0, '0);
        spot = '{pc: 16'h0011, cnt: '0, full: 1'b0, empty: 1'b1, err: 1'b0};
        compare("lifo", dut_view(), spot);

        // fill, overflow, clear
        for (int k = 0; k < D + 1; k++) step(0, 0, 1, 0, 0, W'($urandom));
        step(1, 0, 0, 0, 0, '0);

        // underflow then inc keeps err
        step(0, 1, 0, 0, 0, '0);
        step(0, 0, 0, 0, 1, '0);

        // priority
        step(1, 0, 0, 0, 0, '0);
        step(0, 0, 1, 0, 0, 16'h1000);
        step(0, 0, 1, 0, 0, 16'h2000);
        step(1, 1, 1, 1, 1, 16'h3000);
        step(0, 0, 1, 0, 0, 16'h4000);
        step(0, 1, 1, 0, 1, 16'h5000);

        // wrap and asynchronous reset mid-sequence
        step(0, 0, 0, 1, 0, 16'hFFFF);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 1, 0, 16'hFFFF);
        step(0, 0, 1, 0, 0, 16'h0005);
        step(0, 0, 1, 0, 0, 16'h1234);
        do_reset("async_rst");
        step(0, 1, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 0), W'($urandom));
            if ($urandom_range(0, 149) == 0) do_reset("rand_rst");
        end

        step(0, 0, 0, 0, 0, '0);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nand_pc_stack.md
NAND_PC_STACK -- requirements
Module: nand_pc_stack

Interface
REQ-001 Parameter WIDTH, default 16, is the bit width of the program counter and of each stack entry; legal range 2..32.
REQ-002 Parameter DEPTH, default 8, is the number of return-address stack entries; legal range 1..64.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 Port clr  input  1  is the synchronous clear command.
REQ-006 Port ret  input  1  is the return command: pop the stack into the PC.
REQ-007 Port call  input  1  is the call command: push PC+1 and jump to in.
REQ-008 Port load  input  1  is the jump command: PC takes in.
REQ-009 Port inc  input  1  is the increment command: PC takes PC+1.
REQ-010 Port in  input  WIDTH  is the jump/call target address.
REQ-011 Port out  output  WIDTH  is the current PC value, driven directly from a register.
REQ-012 Port count  output  clog2(DEPTH+1)  is the number of valid stack entries.
REQ-013 Port full  output  1  is high when count == DEPTH.
REQ-014 Port empty  output  1  is high when count == 0.
REQ-015 Port err  output  1  is the sticky overflow/underflow flag.

Function
REQ-016 Command priority per cycle SHALL be clr > ret > call > load > inc > hold; only the highest-priority asserted command takes effect.
REQ-017 clr SHALL set out=0 and count=0, and clear err, on the next edge.
REQ-018 ret with count>0 SHALL set out = top entry and decrement count on the next edge.
REQ-019 ret with count==0 (underflow) SHALL set err=1 and leave out and count unchanged.
REQ-020 call with count<DEPTH SHALL write (out+1) mod 2^WIDTH to entry[count], increment count, and set out=in, all on the same edge.
REQ-021 call with count==DEPTH (overflow) SHALL set err=1 and leave out, count and stack contents unchanged.
REQ-022 load SHALL set out=in; count is unchanged.
REQ-023 inc SHALL set out=(out+1) mod 2^WIDTH; all-ones SHALL wrap to 0 with no flag.
REQ-024 With no command asserted, out, count and err SHALL hold.
REQ-025 Latency: every command is sampled on a rising edge and is visible on out/count one edge later; out SHALL have no combinational path from any input.
REQ-026 full and empty SHALL be decoded combinationally from the count register only.
REQ-027 err SHALL remain 1 once set, until clr or reset.
REQ-028 The stack SHALL be LIFO: after n calls and n rets with no over/underflow, out equals the address that followed the first call.
REQ-029 Entries above count are unobservable; their contents are don't-care.

Reset
REQ-030 rst_n low SHALL immediately (without clk) force out=0, count=0 and err=0; as a consequence empty=1 and full=0.
REQ-031 Reset asserted in the middle of a call/ret sequence SHALL discard all pending stack state; the first command after release SHALL act on an empty stack.
REQ-032 Stack storage need not be reset.
REQ-033 After rst_n rises, commands SHALL be honoured from the first rising edge at which rst_n is sampled high.

Verification
REQ-034 Reset, then inc x3 -> out=0,1,2,3; then load in=0x0100 -> out=0x0100, count=0.
REQ-035 out=0x0010: call in=0x0200 -> out=0x0200, count=1, top=0x0011; then call in=0x0300 -> count=2; then ret -> out=0x0201; then ret -> out=0x0011, empty=1.
REQ-036 With DEPTH=8: 8 calls -> full=1; 9th call -> err=1, count=8, out unchanged; then clr -> out=0, count=0, err=0.
REQ-037 From empty: ret -> err=1, out unchanged; then inc -> out+1 with err still 1.
REQ-038 Assert clr, ret, call, load and inc together with count=2 -> clr wins: out=0, count=0. Then ret+call+inc together with count=1 -> pop only.
REQ-039 out=0xFFFF (WIDTH=16): inc -> out=0x0000. out=0xFFFF: call in=0x0005 -> pushed 0x0000, out=0x0005. Pulse rst_n low mid-sequence -> out=0, count=0 asynchronously.
